exe_stage_gen: RTL and testbench
================================

# exe_stage_gen

Parametrised execute stage for the 5-stage pipeline, successor to the fixed 32-bit EX stage. Holds the ID/EX pipeline register with valid/ready handshake and flush, forwards operands from MEM and WB, and runs the ALU and branch-target adder. Optionally includes an iterative multiply/divide unit that stalls ID while it runs. Sits between decode and the MEM-stage register.

## Interface
- `XLEN`, 32: datapath width (≥8, power of 2)
- `REGW`, 5: register-index width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `id_valid` in 1: ID presents an instruction
- `id_ready` out 1: EX accepts this cycle
- `flush` in 1: kill the instruction in EX (taken branch)
- `id_inA`, `id_inB`, `id_imm`, `id_pc4` in XLEN: operands, extended immediate, PC+4
- `id_aluc` in 4: ALU op; `id_aluimm`, `id_shift`, `id_wreg`, `id_m2reg`, `id_wmem`, `id_branch`, `id_regrt` in 1: decode controls
- `id_rs`, `id_rt`, `id_rd` in REGW: register indices
- `id_md` in 2: 00 none, 01 MUL (low half), 10 DIVU, 11 REMU
- `mem_wreg` in 1, `mem_destR` in REGW, `mem_aluR` in XLEN: MEM forwarding source
- `wb_wreg` in 1, `wb_destR` in REGW, `wb_data` in XLEN: WB forwarding source
- `ex_valid` out 1: EX result valid this cycle
- `ex_wreg`, `ex_m2reg`, `ex_wmem`, `ex_branch`, `ex_zero` out 1
- `ex_aluR`, `ex_inB`, `ex_pc` out XLEN; `ex_destR` out REGW

## Operation
- Capture: on a `clk` edge with `id_valid && id_ready && !flush`, all `id_*` are registered and `e_valid` is set. With `id_valid=0`, `e_valid` clears.
- `flush=1`: `e_valid` clears at the next edge regardless of `id_valid`; any MDU operation aborts.
- `ex_wreg`, `ex_wmem`, `ex_branch`, and `ex_m2reg` are gated by `ex_valid`, so a bubble never writes.
- Forwarding, per operand A (index `e_rs`) and B (index `e_rt`):
  - If the index is nonzero, `mem_wreg=1` and `mem_destR` matches, use `mem_aluR`.
  - Else if `wb_wreg=1` and `wb_destR` matches, use `wb_data`.
  - Else use the captured value.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand muxes:
  - `a_in = e_shift ? zext(e_imm[6 +: log2 XLEN]) : fwdA`
  - `b_in = e_aluimm ? e_imm : fwdB`
  - `ex_inB = fwdB`
- ALU codes:
  - ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010
  - LUI 0110 (`b_in << XLEN/2`)
  - SLL 0011, SRL 0111, SRA 1111; shift amount is `a_in[log2 XLEN-1:0]`
  - Undefined codes give 0.
  - All arithmetic is modulo 2^XLEN.
- `ex_zero = (ex_aluR == 0)`.
- `ex_pc = e_pc4 + e_imm`, modulo 2^XLEN.
- `ex_destR = e_regrt ? e_rt : e_rd`.
- MDU FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY when `e_valid && e_md!=0`; operands are latched from the forwarded values and the counter is loaded with XLEN-1.
  - BUSY decrements the counter each cycle and moves to DONE at 0.
  - DONE→IDLE unconditionally.
  - `flush` or reset forces IDLE from any state.
- Unsigned arithmetic only.
  - DIVU/REMU by zero gives quotient all-ones and remainder equal to the dividend.
  - MUL returns the low XLEN bits.
- `id_ready = !(e_valid && e_md!=0 && state!=DONE)`.
- `ex_valid = e_valid && (e_md==0 || state==DONE)`.
- In DONE, `ex_aluR` is the MDU result.

## Timing
- Reset (`rst_n=0` at an edge) sets `e_valid=0`, FSM to IDLE, and all pipeline registers to 0. All outputs read 0 except `id_ready=1`.
- ALU instructions: 1-cycle latency. Results are valid in the cycle after capture, with full throughput.
- MDU instructions occupy EX for XLEN+2 cycles: 1 IDLE-detect cycle, XLEN BUSY cycles, and 1 DONE cycle.
  - `id_ready=0` from the cycle after capture through the last BUSY cycle.
  - In DONE, `id_ready=1`, so the next instruction is captured at the end of DONE.
- Forwarding is combinational from the current-cycle MEM/WB inputs. During an MDU stall, forwarded values are sampled only at IDLE→BUSY.
- `flush` together with `id_valid && id_ready`: flush wins and nothing is captured.
- `rst_n=0` mid-MDU: abort, and the reset values apply at the next edge.

## Configuration
- `EXE_STAGE_MDU_EN` defined: the MDU, FSM and stall logic are compiled in.
- Undefined:
  - `id_md` is ignored and the MDU is absent.
  - `id_ready = 1` always.
  - `ex_valid = e_valid`.
  - Every instruction takes 1 cycle.

## Structure
- Package `exe_pkg`:
  - ALU op localparams (`ALU_ADD` … `ALU_SRA`)
  - MD op encoding
  - MDU state enum
- Sub-module `mdu_iter`: radix-2 shift-add multiplier / restoring divider.
  - Ports: start, abort, op, a, b; outputs done and result.
  - Instantiated only under `EXE_STAGE_MDU_EN`.

## Test plan
- Reset, then ADD with A=5, B=7 → `ex_valid=1`, `ex_aluR=12`, `ex_zero=0` one cycle after capture; SUB 7−7 → `ex_zero=1`.
- Forwarding: `e_rs=3`, `mem_destR=3` with `mem_aluR=0xAA`, and `wb_destR=3` with `wb_data=0xBB` → A=0xAA. Repeat with `e_rs=0` → captured value is used.
- SRA with imm shamt=4 and B=0x80000000 (XLEN=32) → `0xF8000000`. Branch with pc4=0x100 and imm=0x40 → `ex_pc=0x140`.
- `EXE_STAGE_MDU_EN` with MUL 0xFFFF×0x10001 → `ex_aluR=0xFFFFFFFF` after exactly 34 cycles. `id_ready` is low for 33 cycles, and ADD is captured at the end of DONE.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → all-ones; REMU x/0 → x.
- Flush in BUSY cycle 10 → `ex_valid` never rises, `id_ready=1` next cycle, FSM IDLE. `rst_n=0` in BUSY → same, with all outputs 0.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, multiply/divide
// operation codes and the MDU sequencer state type.
package exe_pkg;

    // ALU operation codes carried on id_aluc / e_aluc
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Multiply/divide selector carried on id_md / e_md
    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_DIVU = 2'b10;
    localparam logic [1:0] MD_REMU = 2'b11;

    // Iterative multiply/divide sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/exe_stage_gen_mdu.sv
// mdu_iter: radix-2 shift-add multiplier (low half) and restoring unsigned
// divider sharing one accumulator. One bit per BUSY cycle, XLEN BUSY cycles.
// Divide by zero falls out of the algorithm: every trial subtract succeeds,
// so the quotient is all-ones and the remainder ends up equal to the dividend.
module mdu_iter
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result,
    output mdu_state_t      state
);

    localparam int LOG = $clog2(XLEN);

    mdu_state_t      state_nxt;
    logic [LOG-1:0]  cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc;   // product / partial remainder
    logic [XLEN-1:0] x;     // multiplicand / dividend shifting into quotient
    logic [XLEN-1:0] y;     // multiplier / divisor
    logic [XLEN:0]   div_r; // partial remainder with next dividend bit

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= MDU_IDLE;
        else        state <= state_nxt;
    end

    // Next state: start only honoured in IDLE, abort wins from any state
    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: if (start) state_nxt = MDU_BUSY;
            MDU_BUSY: if (cnt == '0) state_nxt = MDU_DONE;
            MDU_DONE: state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
        if (abort) state_nxt = MDU_IDLE;
    end

    // Shifted partial remainder for the restoring divide step
    always_comb begin
        div_r = {acc, x[XLEN-1]};
    end

    // Operand latch on start, one iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            x    <= '0;
            y    <= '0;
            op_q <= MD_NONE;
            cnt  <= '0;
        end else if (!abort) begin
            if (state == MDU_IDLE && start) begin
                acc  <= '0;
                x    <= a;
                y    <= b;
                op_q <= op;
                cnt  <= LOG'(XLEN - 1);
            end else if (state == MDU_BUSY) begin
                cnt <= cnt - 1'b1;
                if (op_q == MD_MUL) begin
                    if (y[0]) acc <= acc + x;
                    x <= x << 1;
                    y <= y >> 1;
                end else if (div_r >= {1'b0, y}) begin
                    acc <= XLEN'(div_r - {1'b0, y});
                    x   <= {x[XLEN-2:0], 1'b1};
                end else begin
                    acc <= div_r[XLEN-1:0];
                    x   <= {x[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    assign done   = (state == MDU_DONE);
    assign result = (op_q == MD_DIVU) ? x : acc;

endmodule

// File: rtl/exe_stage_gen.sv
// exe_stage_gen: parametrised execute stage. ID/EX register with handshake
// and flush, MEM/WB operand forwarding, ALU and branch-target adder.
// Optional iterative MUL/DIVU/REMU unit, compiled in with EXE_STAGE_MDU_EN;
// while it runs, id_ready is held low to stall decode.
//
// Handshake: an instruction moves from ID into EX on a rising edge where
// id_valid && id_ready && !flush. When id_ready is high and id_valid is low,
// EX becomes a bubble. When id_ready is low, EX holds its contents.
// ex_valid marks the cycle in which the EX result may be consumed.
//
// mdu_state exposes the sequencer state (IDLE when the MDU is absent).
module exe_stage_gen
    import exe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] id_inA,
    input  logic [XLEN-1:0] id_inB,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc4,
    input  logic [3:0]      id_aluc,
    input  logic            id_aluimm,
    input  logic            id_shift,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic            id_wmem,
    input  logic            id_branch,
    input  logic            id_regrt,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic [1:0]      id_md,
    input  logic            mem_wreg,
    input  logic [REGW-1:0] mem_destR,
    input  logic [XLEN-1:0] mem_aluR,
    input  logic            wb_wreg,
    input  logic [REGW-1:0] wb_destR,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic            ex_wreg,
    output logic            ex_m2reg,
    output logic            ex_wmem,
    output logic            ex_branch,
    output logic            ex_zero,
    output logic [XLEN-1:0] ex_aluR,
    output logic [XLEN-1:0] ex_inB,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_destR,
    output logic [1:0]      mdu_state
);

    localparam int LOG = $clog2(XLEN);

    logic            e_valid;
    logic [XLEN-1:0] e_inA, e_inB, e_imm, e_pc4;
    logic [3:0]      e_aluc;
    logic            e_aluimm, e_shift, e_wreg, e_m2reg, e_wmem, e_branch, e_regrt;
    logic [REGW-1:0] e_rs, e_rt, e_rd;
    logic [1:0]      e_md;

    logic [XLEN-1:0] fwd_a, fwd_b, a_in, b_in, alu_r;
    logic [LOG-1:0]  shamt;

    // ID/EX pipeline register: flush kills, a stall holds, otherwise load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid  <= 1'b0;
            e_inA    <= '0;
            e_inB    <= '0;
            e_imm    <= '0;
            e_pc4    <= '0;
            e_aluc   <= '0;
            e_aluimm <= 1'b0;
            e_shift  <= 1'b0;
            e_wreg   <= 1'b0;
            e_m2reg  <= 1'b0;
            e_wmem   <= 1'b0;
            e_branch <= 1'b0;
            e_regrt  <= 1'b0;
            e_rs     <= '0;
            e_rt     <= '0;
            e_rd     <= '0;
            e_md     <= MD_NONE;
        end else if (flush) begin
            e_valid <= 1'b0;
        end else if (id_ready) begin
            e_valid <= id_valid;
            if (id_valid) begin
                e_inA    <= id_inA;
                e_inB    <= id_inB;
                e_imm    <= id_imm;
                e_pc4    <= id_pc4;
                e_aluc   <= id_aluc;
                e_aluimm <= id_aluimm;
                e_shift  <= id_shift;
                e_wreg   <= id_wreg;
                e_m2reg  <= id_m2reg;
                e_wmem   <= id_wmem;
                e_branch <= id_branch;
                e_regrt  <= id_regrt;
                e_rs     <= id_rs;
                e_rt     <= id_rt;
                e_rd     <= id_rd;
`ifdef EXE_STAGE_MDU_EN
                e_md     <= id_md;
`else
                e_md     <= MD_NONE;
`endif
            end
        end
    end

    // Operand forwarding: MEM beats WB, register 0 never forwarded
    always_comb begin
        fwd_a = e_inA;
        if (e_rs != '0 && mem_wreg && mem_destR == e_rs)     fwd_a = mem_aluR;
        else if (e_rs != '0 && wb_wreg && wb_destR == e_rs)  fwd_a = wb_data;
        fwd_b = e_inB;
        if (e_rt != '0 && mem_wreg && mem_destR == e_rt)     fwd_b = mem_aluR;
        else if (e_rt != '0 && wb_wreg && wb_destR == e_rt)  fwd_b = wb_data;
    end

    // ALU operand selection; shift amount comes from the immediate's shamt field
    always_comb begin
        a_in  = e_shift ? XLEN'(LOG'(e_imm >> 6)) : fwd_a;
        b_in  = e_aluimm ? e_imm : fwd_b;
        shamt = a_in[LOG-1:0];
    end

    // ALU: undefined opcodes produce zero
    always_comb begin
        alu_r = '0;
        case (e_aluc)
            ALU_ADD: alu_r = a_in + b_in;
            ALU_SUB: alu_r = a_in - b_in;
            ALU_AND: alu_r = a_in & b_in;
            ALU_OR:  alu_r = a_in | b_in;
            ALU_XOR: alu_r = a_in ^ b_in;
            ALU_LUI: alu_r = b_in << (XLEN / 2);
            ALU_SLL: alu_r = b_in << shamt;
            ALU_SRL: alu_r = b_in >> shamt;
            ALU_SRA: alu_r = XLEN'($signed(b_in) >>> shamt);
            default: alu_r = '0;
        endcase
    end

`ifdef EXE_STAGE_MDU_EN
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;
    mdu_state_t      mdu_st;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (e_valid && e_md != MD_NONE),
        .abort  (flush),
        .op     (e_md),
        .a      (fwd_a),
        .b      (fwd_b),
        .done   (mdu_done),
        .result (mdu_result),
        .state  (mdu_st)
    );

    assign id_ready  = !(e_valid && e_md != MD_NONE && !mdu_done);
    assign ex_valid  = e_valid && (e_md == MD_NONE || mdu_done);
    assign ex_aluR   = mdu_done ? mdu_result : alu_r;
    assign mdu_state = mdu_st;
`else
    logic unused_md;
    assign unused_md = ^{id_md, e_md};
    assign id_ready  = 1'b1;
    assign ex_valid  = e_valid;
    assign ex_aluR   = alu_r;
    assign mdu_state = MDU_IDLE;
`endif

    // Side-effect controls and the zero flag are qualified so a bubble reads 0
    assign ex_wreg   = ex_valid & e_wreg;
    assign ex_m2reg  = ex_valid & e_m2reg;
    assign ex_wmem   = ex_valid & e_wmem;
    assign ex_branch = ex_valid & e_branch;
    assign ex_zero   = ex_valid && (ex_aluR == '0);
    assign ex_inB    = fwd_b;
    assign ex_pc     = e_pc4 + e_imm;
    assign ex_destR  = e_regrt ? e_rt : e_rd;

endmodule

// File: tb/tb_exe_stage_gen.sv
// Directed bench for exe_stage_gen (XLEN=32, REGW=5). MDU vectors are
// compiled when EXE_STAGE_MDU_EN is defined, matching the DUT build.
module tb_exe_stage_gen;
    import exe_pkg::*;

    logic        clk, rst_n;
    logic        id_valid, id_ready, flush;
    logic [31:0] id_inA, id_inB, id_imm, id_pc4;
    logic [3:0]  id_aluc;
    logic        id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem, id_branch, id_regrt;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_md;
    logic        mem_wreg, wb_wreg;
    logic [4:0]  mem_destR, wb_destR;
    logic [31:0] mem_aluR, wb_data;
    logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
    logic [31:0] ex_aluR, ex_inB, ex_pc;
    logic [4:0]  ex_destR;
    logic [1:0]  mdu_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    exe_stage_gen #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .flush(flush),
        .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_branch(id_branch), .id_regrt(id_regrt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_md(id_md),
        .mem_wreg(mem_wreg), .mem_destR(mem_destR), .mem_aluR(mem_aluR),
        .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_aluR(ex_aluR), .ex_inB(ex_inB),
        .ex_pc(ex_pc), .ex_destR(ex_destR), .mdu_state(mdu_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_inA = 0; id_inB = 0; id_imm = 0; id_pc4 = 0; id_aluc = 0;
        id_aluimm = 0; id_shift = 0; id_wreg = 0; id_m2reg = 0; id_wmem = 0;
        id_branch = 0; id_regrt = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_md = 0;
    endtask

    task automatic load_op(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic aluimm, input logic shift);
        id_aluc = aluc; id_inA = a; id_inB = b; id_imm = imm;
        id_aluimm = aluimm; id_shift = shift;
    endtask

    task automatic fire();
        id_valid = 1;
        tick();
        id_valid = 0;
    endtask

`ifdef EXE_STAGE_MDU_EN
    // Issue an MDU op, wait for ex_valid, check result, latency and stall length
    task automatic run_md(input string tag, input logic [1:0] md, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic drain);
        int k;
        int low;
        id_clear();
        load_op(ALU_ADD, a, b, 0, 0, 0);
        id_md = md;
        id_wreg = 1;
        fire();
        id_md = 0;
        k = 0;
        low = 0;
        while (!ex_valid && k < 100) begin
            if (!id_ready) low++;
            tick();
            k++;
        end
        check({tag, "_res"}, ex_aluR, exp);
        check({tag, "_lat"}, k + 1, 34);
        check({tag, "_stall"}, low, 33);
        check({tag, "_rdy_done"}, id_ready, 1);
        if (drain) tick();
    endtask
`endif

    initial begin
        int seen;
        rst_n = 0; flush = 0;
        mem_wreg = 0; mem_destR = 0; mem_aluR = 0;
        wb_wreg = 0; wb_destR = 0; wb_data = 0;
        id_clear();
        tick(); tick();

        // Reset state
        check("rst_valid", ex_valid, 0);
        check("rst_ready", id_ready, 1);
        check("rst_aluR", ex_aluR, 0);
        check("rst_zero", ex_zero, 0);
        check("rst_pc", ex_pc, 0);
        check("rst_inB", ex_inB, 0);
        check("rst_dest", ex_destR, 0);
        check("rst_wreg", ex_wreg, 0);
        check("rst_state", mdu_state, 0);
        rst_n = 1;
        tick();

        // ADD 5+7, then a bubble
        id_clear();
        load_op(ALU_ADD, 5, 7, 0, 0, 0);
        id_rs = 1; id_rt = 2; id_rd = 9; id_wreg = 1; id_m2reg = 1; id_wmem = 1;
        fire();
        check("add_valid", ex_valid, 1);
        check("add_res", ex_aluR, 12);
        check("add_zero", ex_zero, 0);
        check("add_dest", ex_destR, 9);
        check("add_wreg", ex_wreg, 1);
        check("add_m2reg", ex_m2reg, 1);
        check("add_wmem", ex_wmem, 1);
        tick();
        check("bub_valid", ex_valid, 0);
        check("bub_wreg", ex_wreg, 0);
        check("bub_m2reg", ex_m2reg, 0);
        check("bub_wmem", ex_wmem, 0);

        // SUB 7-7 sets zero
        id_clear();
        load_op(ALU_SUB, 7, 7, 0, 0, 0);
        fire();
        check("sub_res", ex_aluR, 0);
        check("sub_zero", ex_zero, 1);

        // Forwarding A: MEM beats WB, then WB alone, then register 0
        id_clear();
        load_op(ALU_ADD, 32'h11, 1, 0, 0, 0);
        id_rs = 3;
        mem_wreg = 1; mem_destR = 3; mem_aluR = 32'hAA;
        wb_wreg = 1; wb_destR = 3; wb_data = 32'hBB;
        fire();
        check("fwd_mem", ex_aluR, 32'hAB);
        mem_wreg = 0;
        #1;
        check("fwd_wb", ex_aluR, 32'hBC);
        mem_wreg = 1; mem_destR = 0; wb_destR = 0;
        id_rs = 0;
        fire();
        check("fwd_r0", ex_aluR, 32'h12);

        // Forwarding B feeds both ex_inB and the ALU
        id_clear();
        load_op(ALU_ADD, 1, 32'h22, 0, 0, 0);
        id_rt = 3;
        mem_wreg = 1; mem_destR = 3; mem_aluR = 32'hAA;
        fire();
        check("fwdb_inB", ex_inB, 32'hAA);
        check("fwdb_res", ex_aluR, 32'hAB);
        mem_wreg = 0; wb_wreg = 0;
        #1;
        check("fwdb_none", ex_inB, 32'h22);

        // Immediate operand: ex_inB still shows the register value
        id_clear();
        load_op(ALU_ADD, 10, 99, 5, 1, 0);
        fire();
        check("imm_res", ex_aluR, 15);
        check("imm_inB", ex_inB, 99);

        // Shifts with shamt=4 in imm[10:6], logic ops, LUI, undefined code
        id_clear();
        load_op(ALU_SRA, 0, 32'h80000000, 32'h100, 0, 1);
        fire();
        check("sra", ex_aluR, 32'hF8000000);
        load_op(ALU_SRL, 0, 32'h80000000, 32'h100, 0, 1);
        fire();
        check("srl", ex_aluR, 32'h08000000);
        load_op(ALU_SLL, 0, 1, 32'h100, 0, 1);
        fire();
        check("sll", ex_aluR, 32'h10);
        load_op(ALU_AND, 32'hF0F0, 32'hFF00, 0, 0, 0);
        fire();
        check("and", ex_aluR, 32'hF000);
        load_op(ALU_OR, 32'hF0F0, 32'hFF00, 0, 0, 0);
        fire();
        check("or", ex_aluR, 32'hFFF0);
        load_op(ALU_XOR, 32'hF0F0, 32'hFF00, 0, 0, 0);
        fire();
        check("xor", ex_aluR, 32'h0FF0);
        load_op(ALU_LUI, 0, 32'hDEAD, 32'h1234, 1, 0);
        fire();
        check("lui", ex_aluR, 32'h12340000);
        load_op(4'b1000, 3, 4, 0, 0, 0);
        fire();
        check("undef_res", ex_aluR, 0);
        check("undef_zero", ex_zero, 1);
        load_op(ALU_ADD, 32'hFFFFFFFF, 2, 0, 0, 0);
        fire();
        check("add_wrap", ex_aluR, 1);

        // Branch target and rt destination
        id_clear();
        load_op(ALU_SUB, 4, 4, 32'h40, 0, 0);
        id_pc4 = 32'h100; id_branch = 1; id_regrt = 1; id_rt = 6; id_rd = 9;
        fire();
        check("br_pc", ex_pc, 32'h140);
        check("br_flag", ex_branch, 1);
        check("br_dest", ex_destR, 6);

        // Flush kills EX and wins over a simultaneous capture
        id_clear();
        load_op(ALU_ADD, 1, 1, 0, 0, 0);
        id_wreg = 1;
        fire();
        check("pre_flush", ex_valid, 1);
        load_op(ALU_ADD, 2, 2, 0, 0, 0);
        id_valid = 1; flush = 1;
        tick();
        id_valid = 0; flush = 0;
        check("flush_valid", ex_valid, 0);
        check("flush_wreg", ex_wreg, 0);

        // Back-to-back ALU ops at full throughput
        id_clear();
        for (int i = 0; i < 4; i++) begin
            load_op(ALU_ADD, i * 3, 100, 0, 0, 0);
            id_valid = 1;
            exp_q.push_back(i * 3 + 100);
            tick();
            check("thr_valid", ex_valid, 1);
            check("thr_ready", id_ready, 1);
            check("thr_res", ex_aluR, exp_q.pop_front());
        end
        id_valid = 0;
        tick();

`ifdef EXE_STAGE_MDU_EN
        // MUL timing, then ADD captured at the end of DONE
        run_md("mul", MD_MUL, 32'hFFFF, 32'h10001, 32'hFFFFFFFF, 0);
        check("mul_wreg", ex_wreg, 1);
        id_clear();
        load_op(ALU_ADD, 2, 3, 0, 0, 0);
        fire();
        check("after_mul_valid", ex_valid, 1);
        check("after_mul_res", ex_aluR, 5);
        check("after_mul_state", mdu_state, 0);
        tick();

        run_md("divu", MD_DIVU, 100, 7, 14, 1);
        run_md("remu", MD_REMU, 100, 7, 2, 1);
        run_md("divu0", MD_DIVU, 32'h1234, 0, 32'hFFFFFFFF, 1);
        run_md("remu0", MD_REMU, 32'h1234, 0, 32'h1234, 1);

        // Flush in BUSY cycle 10
        id_clear();
        load_op(ALU_ADD, 100, 7, 0, 0, 0);
        id_md = MD_DIVU;
        fire();
        id_md = 0;
        tick();
        for (int i = 2; i <= 10; i++) tick();
        check("fl_busy", mdu_state, 1);
        flush = 1;
        tick();
        flush = 0;
        check("fl_valid", ex_valid, 0);
        check("fl_ready", id_ready, 1);
        check("fl_state", mdu_state, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ex_valid) seen++;
        end
        check("fl_never", seen, 0);

        // Reset while BUSY
        id_clear();
        load_op(ALU_ADD, 9, 9, 32'h40, 0, 0);
        id_md = MD_MUL; id_pc4 = 32'h10; id_rd = 7;
        fire();
        id_md = 0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0;
        tick();
        check("rb_valid", ex_valid, 0);
        check("rb_ready", id_ready, 1);
        check("rb_aluR", ex_aluR, 0);
        check("rb_pc", ex_pc, 0);
        check("rb_dest", ex_destR, 0);
        check("rb_state", mdu_state, 0);
        rst_n = 1;
        tick();
`else
        // Without the MDU, id_md is ignored and every op is single-cycle
        id_clear();
        load_op(ALU_ADD, 3, 4, 0, 0, 0);
        id_md = MD_MUL;
        fire();
        id_md = 0;
        check("nomdu_valid", ex_valid, 1);
        check("nomdu_res", ex_aluR, 7);
        check("nomdu_ready", id_ready, 1);
        check("nomdu_state", mdu_state, 0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
